handshake_const_arbiter: RTL and testbench



---
 rtl/handshake_const_pkg.sv | 30 +++
 rtl/handshake_rr_arbiter.sv | 31 +++
 rtl/handshake_const_arbiter.sv | 85 ++++++++
 tb/tb_handshake_const_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/handshake_const_pkg.sv
// Shared defaults and helpers for the constant-source arbiter and related
// shared-resource controllers.
package handshake_const_pkg;

  function automatic int hc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int HC_DATA_WIDTH = 17;
  localparam int HC_NUM_REQ    = 4;
  localparam int HC_IDX_WIDTH  = hc_clog2(HC_NUM_REQ);

  // Upper bounds on a constant entry and on a whole packed table.
  localparam int HC_MAX_DW     = 64;
  localparam int HC_MAX_TBL_W  = 1024;

  function automatic logic [HC_MAX_DW-1:0] hc_table_entry(
    input logic [HC_MAX_TBL_W-1:0] tbl,
    input int                      idx,
    input int                      dw
  );
    logic [HC_MAX_TBL_W-1:0] sh;
    sh = tbl >> (idx * dw);
    return sh[HC_MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr_i,
// wrapping modulo NUM_REQ, wins.
module handshake_rr_arbiter
  import handshake_const_pkg::*;
#(
  parameter int NUM_REQ   = HC_NUM_REQ,
  parameter int IDX_WIDTH = HC_IDX_WIDTH
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [IDX_WIDTH-1:0] winner_o,
  output logic                 any_grant_o
);

  always_comb begin
    int idx;
    grant_o     = '0;
    winner_o    = '0;
    any_grant_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/handshake_const_arbiter.sv
// Shares one registered constant output slot among NUM_REQ control requesters;
// each accepted token loads that requester's table constant and index.
module handshake_const_arbiter
  import handshake_const_pkg::*;
#(
  parameter int                              DATA_WIDTH  = HC_DATA_WIDTH,
  parameter int                              NUM_REQ     = HC_NUM_REQ,
  parameter int                              IDX_WIDTH   = HC_IDX_WIDTH,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0]   CONST_TABLE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_WIDTH-1:0]  winner;
  logic                  any_grant;
  logic                  can_load;
  logic                  accept;
  logic [DATA_WIDTH-1:0] winner_const;

  handshake_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .req_i       (ctrl_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_grant_o (any_grant)
  );

  // A drain and a load may share a cycle, giving one token per cycle.
  assign can_load   = !full_q || outs_ready;
  assign ctrl_ready = rst ? '0 : (grant & {NUM_REQ{can_load}});
  assign accept     = !rst && any_grant && can_load;

  assign winner_const = DATA_WIDTH'(hc_table_entry(HC_MAX_TBL_W'(CONST_TABLE),
                                                   int'(winner), DATA_WIDTH));

  always_comb begin
    full_d   = full_q;
    outs_d   = outs_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      full_d   = 1'b1;
      outs_d   = winner_const;
      idx_d    = winner;
      rr_ptr_d = (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + IDX_WIDTH'(1);
    end else if (full_q && outs_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 1'b0;
      outs_q   <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      full_q   <= full_d;
      outs_q   <= outs_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign outs       = outs_q;
  assign outs_index = idx_q;
  assign outs_valid = full_q;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Scenario bench for handshake_const_arbiter with a queue scoreboard of
// expected {index, constant} tokens popped as the output slot drains.
module tb_handshake_const_arbiter;

  localparam int DW = 17;
  localparam int NR = 4;
  localparam int IW = 2;

  localparam logic [DW-1:0] E0 = 17'h00011;
  localparam logic [DW-1:0] E1 = 17'h1ABCD;
  localparam logic [DW-1:0] E2 = 17'h080E7;
  localparam logic [DW-1:0] E3 = 17'h1FFFF;
  localparam logic [NR*DW-1:0] TABLE = {E3, E2, E1, E0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] ctrl_valid = 4'b1111;
  logic [NR-1:0] ctrl_ready;
  logic [DW-1:0] outs;
  logic [IW-1:0] outs_index;
  logic          outs_valid;
  logic          outs_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [IW+DW-1:0] sb_q[$];

  handshake_const_arbiter #(
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NR),
    .IDX_WIDTH   (IW),
    .CONST_TABLE (TABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] entry(input int i);
    case (i)
      0: return E0;
      1: return E1;
      2: return E2;
      default: return E3;
    endcase
  endfunction

  // Drive inputs just after a rising edge, return mid-cycle for sampling.
  task automatic drive(input logic r, input logic [NR-1:0] v, input logic o);
    @(posedge clk);
    #1;
    rst        = r;
    ctrl_valid = v;
    outs_ready = o;
    @(negedge clk);
  endtask

  task automatic expect_grant(input string name, input int w);
    logic [NR-1:0] exp_rdy;
    exp_rdy = NR'(1) << w;
    checks++;
    if (ctrl_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s ctrl_ready got %b want %b", name, ctrl_ready, exp_rdy);
    end
    sb_q.push_back({IW'(w), entry(w)});
  endtask

  // Scoreboard consumer: every drain must deliver the oldest expected token.
  always @(negedge clk) begin
    if (!rst && outs_valid === 1'b1 && outs_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_drain unexpected token idx %0d data %h", outs_index, outs);
      end else begin
        if ({outs_index, outs} !== sb_q[0]) begin
          errors++;
          $display("FAIL sb_drain got idx %0d data %h want idx %0d data %h",
                   outs_index, outs, sb_q[0][IW+DW-1:DW], sb_q[0][DW-1:0]);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b1111, 1'b0);
      checks++;
      if (ctrl_ready !== 4'b0000 || outs_valid !== 1'b0 || outs !== '0 || outs_index !== '0) begin
        errors++;
        $display("FAIL reset rdy %b vld %b outs %h idx %0d want 0000 0 0 0",
                 ctrl_ready, outs_valid, outs, outs_index);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b1111, 1'b1);
      expect_grant("rr_grant", c % 4);
      if (c > 0) begin
        checks++;
        if (outs_valid !== 1'b1 || outs_index !== IW'((c - 1) % 4)) begin
          errors++;
          $display("FAIL rr_index got vld %b idx %0d want 1 %0d", outs_valid, outs_index, (c - 1) % 4);
        end
      end
    end
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    checks++;
    if (outs_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_empty outs_valid got %b want 0", outs_valid);
    end
  endtask

  task automatic test_single();
    drive(1'b0, 4'b0100, 1'b1);
    expect_grant("single_grant", 2);
    drive(1'b0, 4'b0000, 1'b1);
    checks++;
    if (outs !== 17'h080E7 || outs_index !== 2'd2 || outs_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out got %h idx %0d vld %b want 080e7 2 1", outs, outs_index, outs_valid);
    end
  endtask

  task automatic test_wrap();
    // Pointer is 3 after granting requester 2 in the previous task.
    drive(1'b0, 4'b1001, 1'b1);
    expect_grant("wrap_grant3", 3);
    drive(1'b0, 4'b1001, 1'b1);
    expect_grant("wrap_grant0", 0);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_backpressure();
    drive(1'b0, 4'b0011, 1'b1);
    expect_grant("bp_load", 1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b0011, 1'b0);
      checks++;
      if (ctrl_ready !== 4'b0000 || outs !== E1 || outs_index !== 2'd1 || outs_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall rdy %b outs %h idx %0d vld %b want 0000 %h 1 1",
                 ctrl_ready, outs, outs_index, outs_valid, E1);
      end
    end
    drive(1'b0, 4'b0011, 1'b1);
    expect_grant("bp_release", 0);
    drive(1'b0, 4'b0000, 1'b1);
    checks++;
    if (outs_valid !== 1'b1 || outs !== E0 || outs_index !== 2'd0) begin
      errors++;
      $display("FAIL bp_reload vld %b outs %h idx %0d want 1 %h 0", outs_valid, outs, outs_index, E0);
    end
    drive(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 4'b0100, 1'b1);
    expect_grant("mid_load", 2);
    drive(1'b0, 4'b1111, 1'b0);
    checks++;
    if (ctrl_ready !== 4'b0000 || outs_valid !== 1'b1 || outs !== E2) begin
      errors++;
      $display("FAIL mid_full rdy %b vld %b outs %h want 0000 1 %h", ctrl_ready, outs_valid, outs, E2);
    end
    drive(1'b1, 4'b1111, 1'b1);
    sb_q.delete();
    checks++;
    if (ctrl_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 0000", ctrl_ready);
    end
    drive(1'b0, 4'b1111, 1'b1);
    checks++;
    if (outs_valid !== 1'b0 || outs !== '0 || outs_index !== '0) begin
      errors++;
      $display("FAIL mid_after_rst vld %b outs %h idx %0d want 0 0 0", outs_valid, outs, outs_index);
    end
    expect_grant("mid_ptr0", 0);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d tokens want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
